// File: rtl/vm_pkg.sv
// Shared types and helpers for the vending-machine controller.
//   vm_state_e   : controller states
//   COIN_IDX_W   : width of a coin denomination index
//   COIN_VAL_W   : width of one packed coin value
//   price_of()   : extract one price from a packed price vector
//   coin_val_of(): extract one coin value from the packed coin table
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } vm_state_e;

  localparam int COIN_IDX_W   = 2;
  localparam int COIN_VAL_W   = 8;
  localparam int MAX_CREDIT_W = 16;
  // Widest packed price vector the helper accepts (8 products x 16 bits).
  localparam int PRICE_VEC_W  = 128;

  function automatic logic [MAX_CREDIT_W-1:0] price_of(
    input logic [PRICE_VEC_W-1:0] prices,
    input int unsigned            credit_w,
    input int unsigned            id
  );
    logic [PRICE_VEC_W-1:0] shifted;
    shifted = prices >> (id * credit_w);
    return MAX_CREDIT_W'(shifted) & MAX_CREDIT_W'((32'd1 << credit_w) - 32'd1);
  endfunction

  function automatic logic [COIN_VAL_W-1:0] coin_val_of(
    input logic [4*COIN_VAL_W-1:0] vals,
    input logic [COIN_IDX_W-1:0]   idx
  );
    return vals[idx*COIN_VAL_W +: COIN_VAL_W];
  endfunction

endpackage

// File: rtl/vm_if.sv
// Front-end / controller bundle for the vending-machine controller.
//   master : front end (coin, selection, cancel, actuator ready) -> controller
//   slave  : controller side (dispense request, credit, status pulses)
interface vm_if #(
  parameter int N_PROD   = 4,
  parameter int CREDIT_W = 6
);
  localparam int ID_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  logic                        coin_valid;
  logic [vm_pkg::COIN_IDX_W-1:0] coin_sel;
  logic                        sel_valid;
  logic [ID_W-1:0]             sel_id;
  logic                        cancel;
  logic                        disp_ready;
  logic                        disp_valid;
  logic [ID_W-1:0]             disp_id;
  logic [CREDIT_W-1:0]         credit;
  logic                        coin_reject;
  logic                        err_insuf;
  logic                        change_pulse;

  modport master (
    output coin_valid, coin_sel, sel_valid, sel_id, cancel, disp_ready,
    input  disp_valid, disp_id, credit, coin_reject, err_insuf, change_pulse
  );

  modport slave (
    input  coin_valid, coin_sel, sel_valid, sel_id, cancel, disp_ready,
    output disp_valid, disp_id, credit, coin_reject, err_insuf, change_pulse
  );

endinterface

// File: rtl/vm_credit_acc.sv
// Saturating credit accumulator.
//   clk, rst      : clock, async active-high reset
//   add_en/add_val: add a coin (caller only asserts add_en when accept_o is high)
//   sub_en/sub_val: subtract a product price
//   dec_en        : subtract one unit (change return)
//   clr_en        : clear to zero, overrides everything else
//   credit_o      : current credit
//   accept_o      : the offered coin fits without exceeding full scale
//   next_zero_o   : credit will be zero after this cycle
module vm_credit_acc import vm_pkg::*; #(
  parameter int CREDIT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  add_en,
  input  logic [COIN_VAL_W-1:0] add_val,
  input  logic                  sub_en,
  input  logic [CREDIT_W-1:0]   sub_val,
  input  logic                  dec_en,
  input  logic                  clr_en,
  output logic [CREDIT_W-1:0]   credit_o,
  output logic                  accept_o,
  output logic                  next_zero_o
);

  // Wide enough for credit + any coin value with no wrap.
  localparam int SUM_W = ((CREDIT_W > COIN_VAL_W) ? CREDIT_W : COIN_VAL_W) + 1;
  localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'((1 << CREDIT_W) - 1);

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SUM_W-1:0]    coin_sum;
  logic [SUM_W-1:0]    next_full;

  assign coin_sum = SUM_W'(credit_q) + SUM_W'(add_val);
  assign accept_o = (coin_sum <= CREDIT_MAX);

  // Price is only subtracted after a grant (credit >= price), so the
  // coin+price combination never goes negative.
  always_comb begin
    next_full = SUM_W'(credit_q);
    if (add_en) next_full = coin_sum;
    if (sub_en) next_full = next_full - SUM_W'(sub_val);
    if (dec_en) next_full = next_full - SUM_W'(1);
    if (clr_en) next_full = '0;
    credit_d = CREDIT_W'(next_full);
  end

  assign next_zero_o = (credit_d == '0);
  assign credit_o    = credit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) credit_q <= '0;
    else     credit_q <= credit_d;
  end

endmodule

// File: rtl/vm_multi_product_fsm.sv
// Vending-machine controller: coin intake, product selection against a
// per-product price, dispense handshake and (optionally) unit change return.
//   clk, rst : clock, async active-high reset
//   bus      : vm_if.slave (coin/selection/cancel/ready in; dispense,
//              credit and status pulses out)
// Optional feature macro: VM_CHANGE_RETURN_EN
//   defined   : leftover credit after a dispense, or on cancel, is paid back
//               one unit per cycle on change_pulse (CHANGE state)
//   undefined : leftover credit is kept; cancel clears credit; change_pulse = 0
//
// state    | meaning
// IDLE     | credit is zero
// CREDIT   | credit is non-zero, waiting for coins/selection/cancel
// DISPENSE | disp_valid held until the actuator takes it
// CHANGE   | returning credit one unit per cycle (macro builds only)
module vm_multi_product_fsm import vm_pkg::*; #(
  parameter int                       N_PROD    = 4,
  parameter int                       CREDIT_W  = 6,
  parameter logic [4*COIN_VAL_W-1:0]  COIN_VALS = {8'd10, 8'd5, 8'd2, 8'd1},
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES  = {6'd12, 6'd9, 6'd5, 6'd3}
) (
  input logic clk,
  input logic rst,
  vm_if.slave bus
);

  localparam int ID_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  vm_state_e           state_q;
  logic                disp_valid_q;
  logic [ID_W-1:0]     disp_id_q;
  logic                coin_reject_q;
  logic                err_insuf_q;

  logic [CREDIT_W-1:0]   credit;
  logic [CREDIT_W-1:0]   price;
  logic [COIN_VAL_W-1:0] coin_val;
  logic                  accept;
  logic                  next_zero;
  logic                  open_st;
  logic                  cancel_hit;
  logic                  sel_live;
  logic                  id_ok;
  logic                  grant;
  logic                  refuse;
  logic                  coin_take;
  logic                  handshake;
  logic                  dec_en;
  logic                  clr_en;

  assign coin_val = coin_val_of(COIN_VALS, bus.coin_sel);
  assign price    = CREDIT_W'(price_of(PRICE_VEC_W'(PRICES), CREDIT_W, 32'(bus.sel_id)));

  assign open_st    = (state_q == IDLE) || (state_q == CREDIT);
  assign cancel_hit = bus.cancel && (state_q == CREDIT);
  // Cancel wins over a selection in the same cycle.
  assign sel_live   = bus.sel_valid && open_st && !cancel_hit;
  assign id_ok      = 32'(bus.sel_id) < N_PROD;
  // Price is checked against the credit before any same-cycle coin lands.
  assign grant      = sel_live && id_ok && (credit >= price);
  assign refuse     = sel_live && !grant;
  // A coin arriving with a cancel is bounced rather than silently absorbed.
  assign coin_take  = bus.coin_valid && open_st && !cancel_hit && accept;
  assign handshake  = disp_valid_q && bus.disp_ready;

`ifdef VM_CHANGE_RETURN_EN
  logic change_pulse_q;
  assign dec_en = (state_q == CHANGE) && (credit != '0);
  assign clr_en = 1'b0;
`else
  assign dec_en = 1'b0;
  assign clr_en = cancel_hit;
`endif

  vm_credit_acc #(
    .CREDIT_W (CREDIT_W)
  ) u_credit_acc (
    .clk         (clk),
    .rst         (rst),
    .add_en      (coin_take),
    .add_val     (coin_val),
    .sub_en      (grant),
    .sub_val     (price),
    .dec_en      (dec_en),
    .clr_en      (clr_en),
    .credit_o    (credit),
    .accept_o    (accept),
    .next_zero_o (next_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      disp_valid_q   <= 1'b0;
      disp_id_q      <= '0;
      coin_reject_q  <= 1'b0;
      err_insuf_q    <= 1'b0;
`ifdef VM_CHANGE_RETURN_EN
      change_pulse_q <= 1'b0;
`endif
    end else begin
      coin_reject_q  <= bus.coin_valid && !coin_take;
      err_insuf_q    <= refuse;
`ifdef VM_CHANGE_RETURN_EN
      change_pulse_q <= dec_en;
`endif
      case (state_q)
        IDLE, CREDIT: begin
          if (cancel_hit) begin
`ifdef VM_CHANGE_RETURN_EN
            state_q <= CHANGE;
`else
            state_q <= IDLE;
`endif
          end else if (grant) begin
            state_q      <= DISPENSE;
            disp_valid_q <= 1'b1;
            disp_id_q    <= bus.sel_id;
          end else begin
            state_q <= next_zero ? IDLE : CREDIT;
          end
        end
        DISPENSE: begin
          if (handshake) begin
            disp_valid_q <= 1'b0;
`ifdef VM_CHANGE_RETURN_EN
            state_q <= next_zero ? IDLE : CHANGE;
`else
            state_q <= next_zero ? IDLE : CREDIT;
`endif
          end
        end
`ifdef VM_CHANGE_RETURN_EN
        CHANGE: begin
          if (next_zero) state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.disp_valid  = disp_valid_q;
  assign bus.disp_id     = disp_id_q;
  assign bus.credit      = credit;
  assign bus.coin_reject = coin_reject_q;
  assign bus.err_insuf   = err_insuf_q;
`ifdef VM_CHANGE_RETURN_EN
  assign bus.change_pulse = change_pulse_q;
`else
  assign bus.change_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_vm_multi_product_fsm.sv
// Self-checking bench for vm_multi_product_fsm (default parameters).
// Coin index 0..3 = 1,2,5,10; product id 0..3 = price 3,5,9,12.
module tb_vm_multi_product_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vm_if #(.N_PROD(4), .CREDIT_W(6)) vif ();

  vm_multi_product_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  typedef struct {
    logic       cv;
    logic [1:0] cs;
    logic       sv;
    logic [1:0] sid;
    logic       cn;
    logic       rdy;
    logic [5:0] e_cr;
    logic       e_rej;
    logic       e_err;
    logic       e_dv;
    logic [1:0] e_id;
  } vec_t;

  vec_t       vecs[$];
  vec_t       exp_q[$];
  logic [1:0] disp_q[$];
  int         checks  = 0;
  int         errors  = 0;
  int         chg_cnt = 0;
  logic [1:0] hs_id;

  function automatic vec_t mk(input logic cv, input logic [1:0] cs, input logic sv,
                              input logic [1:0] sid, input logic cn, input logic rdy,
                              input logic [5:0] cr, input logic rej, input logic err,
                              input logic dv, input logic [1:0] id);
    vec_t v;
    v.cv = cv; v.cs = cs; v.sv = sv; v.sid = sid; v.cn = cn; v.rdy = rdy;
    v.e_cr = cr; v.e_rej = rej; v.e_err = err; v.e_dv = dv; v.e_id = id;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    vif.coin_valid = 1'b0;
    vif.sel_valid  = 1'b0;
    vif.cancel     = 1'b0;
    vif.disp_ready = 1'b0;
  endtask

  task automatic step(input logic cv, input logic [1:0] cs, input logic sv,
                      input logic [1:0] sid, input logic cn, input logic rdy);
    vif.coin_valid = cv;
    vif.coin_sel   = cs;
    vif.sel_valid  = sv;
    vif.sel_id     = sid;
    vif.cancel     = cn;
    vif.disp_ready = rdy;
    tick();
  endtask

`ifdef VM_CHANGE_RETURN_EN
  task automatic drain(input string nm, input int exp_n, input int budget);
    int n;
    n = 0;
    while (vif.credit !== 6'd0 && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, (n < budget), 1);
    tick();
    tick();
    chk({nm, "_pulses"}, chg_cnt, exp_n);
    chk({nm, "_credit"}, vif.credit, 0);
  endtask
`endif

  // Handshake scoreboard and change-pulse counter.
  always @(negedge clk) begin
    if (!rst) begin
      if (vif.change_pulse === 1'b1) chg_cnt++;
      if (vif.disp_valid === 1'b1 && vif.disp_ready === 1'b1) begin
        if (disp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL disp_unexpected: got id %0d expected no dispense", vif.disp_id);
        end else begin
          hs_id = disp_q.pop_front();
          chk("disp_id_hs", vif.disp_id, hs_id);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, e;
    logic prev_dv;

    //          cv cs    sv sid   cn rdy  cr  rej err dv id
    vecs.push_back(mk(1, 2'd2, 0, 2'd0, 0, 0, 6'd5,  0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 2'd2, 0, 2'd0, 0, 0, 6'd10, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 2'd1, 0, 2'd0, 0, 0, 6'd12, 0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 2'd0, 1, 2'd3, 0, 0, 6'd0,  0, 0, 1, 2'd3));
    vecs.push_back(mk(0, 2'd0, 1, 2'd0, 0, 0, 6'd0,  0, 0, 1, 2'd3));
    vecs.push_back(mk(0, 2'd0, 0, 2'd0, 0, 0, 6'd0,  0, 0, 1, 2'd3));
    vecs.push_back(mk(0, 2'd0, 0, 2'd0, 0, 1, 6'd0,  0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 2'd0, 0, 2'd0, 0, 0, 6'd1,  0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 2'd1, 0, 2'd0, 0, 0, 6'd3,  0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 2'd0, 1, 2'd1, 0, 0, 6'd3,  0, 1, 0, 2'd0));
    vecs.push_back(mk(0, 2'd0, 0, 2'd0, 0, 0, 6'd3,  0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 2'd0, 0, 2'd0, 0, 0, 6'd4,  0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 2'd0, 1, 2'd1, 0, 0, 6'd5,  0, 1, 0, 2'd0));
    vecs.push_back(mk(1, 2'd1, 1, 2'd1, 0, 0, 6'd2,  0, 0, 1, 2'd1));
    vecs.push_back(mk(1, 2'd2, 0, 2'd0, 0, 1, 6'd2,  1, 0, 0, 2'd0));

    vif.coin_valid = 1'b0; vif.coin_sel = 2'd0;
    vif.sel_valid  = 1'b0; vif.sel_id   = 2'd0;
    vif.cancel     = 1'b0; vif.disp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", vif.credit, 0);
    chk("rst_disp_valid", vif.disp_valid, 0);
    chk("rst_coin_reject", vif.coin_reject, 0);
    chk("rst_err_insuf", vif.err_insuf, 0);
    chk("rst_change_pulse", vif.change_pulse, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_credit", vif.credit, 0);

    prev_dv = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      exp_q.push_back(v);
      if (v.sv && v.e_dv && !prev_dv) disp_q.push_back(v.sid);
      prev_dv = v.e_dv;
      step(v.cv, v.cs, v.sv, v.sid, v.cn, v.rdy);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_credit", i), vif.credit, e.e_cr);
      chk($sformatf("v%0d_coin_reject", i), vif.coin_reject, e.e_rej);
      chk($sformatf("v%0d_err_insuf", i), vif.err_insuf, e.e_err);
      chk($sformatf("v%0d_disp_valid", i), vif.disp_valid, e.e_dv);
      if (e.e_dv) chk($sformatf("v%0d_disp_id", i), vif.disp_id, e.e_id);
    end

    // Leftover credit 2 after the last dispense.
`ifdef VM_CHANGE_RETURN_EN
    chg_cnt = 0;
    drain("leftover", 2, 20);
`else
    step(0, 2'd0, 0, 2'd0, 1, 0);
    chk("cancel_credit", vif.credit, 0);
`endif

    // Saturation at full scale (63).
    for (int k = 0; k < 6; k++) step(1, 2'd3, 0, 2'd0, 0, 0);
    chk("sat_60", vif.credit, 60);
    step(1, 2'd2, 0, 2'd0, 0, 0);
    chk("sat_rej5", vif.coin_reject, 1);
    chk("sat_rej5_credit", vif.credit, 60);
    step(1, 2'd1, 0, 2'd0, 0, 0);
    chk("sat_62_rej", vif.coin_reject, 0);
    chk("sat_62", vif.credit, 62);
    step(1, 2'd0, 0, 2'd0, 0, 0);
    chk("sat_63", vif.credit, 63);
    step(1, 2'd0, 0, 2'd0, 0, 0);
    chk("sat_full_rej", vif.coin_reject, 1);
    chk("sat_full_credit", vif.credit, 63);

    // Cancel and an affordable selection together: cancel wins.
    step(0, 2'd0, 1, 2'd3, 1, 0);
    chk("cxl_sel_dv", vif.disp_valid, 0);
    chk("cxl_sel_err", vif.err_insuf, 0);
`ifdef VM_CHANGE_RETURN_EN
    chg_cnt = 0;
    drain("cancel63", 63, 100);
`else
    chk("cxl_sel_credit", vif.credit, 0);
`endif

    // Dispense with leftover credit: 10 - 3 = 7.
    step(1, 2'd3, 0, 2'd0, 0, 0);
    chk("left_10", vif.credit, 10);
    disp_q.push_back(2'd0);
    step(0, 2'd0, 1, 2'd0, 0, 0);
    chk("left_dv", vif.disp_valid, 1);
    chk("left_id", vif.disp_id, 0);
    chk("left_credit", vif.credit, 7);
    step(0, 2'd0, 0, 2'd0, 0, 1);
    chk("left_hs_dv", vif.disp_valid, 0);
    chk("left_hs_credit", vif.credit, 7);
`ifdef VM_CHANGE_RETURN_EN
    chg_cnt = 0;
    drain("change7", 7, 30);
`else
    tick();
    tick();
    chk("left_hold", vif.credit, 7);
    // Cancel only acts in CREDIT, so this clearing shows the state.
    step(0, 2'd0, 0, 2'd0, 1, 0);
    chk("left_cancel", vif.credit, 0);
`endif

    // Async reset during a pending dispense.
    step(1, 2'd3, 0, 2'd0, 0, 0);
    step(0, 2'd0, 1, 2'd1, 0, 0);
    chk("rstd_dv_before", vif.disp_valid, 1);
    chk("rstd_credit_before", vif.credit, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("rstd_dv_async", vif.disp_valid, 0);
    chk("rstd_credit_async", vif.credit, 0);
    disp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 2'd1, 0, 2'd0, 0, 0);
    chk("rstd_coin_credit", vif.credit, 2);
    chk("rstd_coin_rej", vif.coin_reject, 0);
    chk("rstd_dv_after", vif.disp_valid, 0);

    chk("disp_q_empty", disp_q.size(), 0);
`ifndef VM_CHANGE_RETURN_EN
    chk("no_change_pulse", chg_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
